spi_slave_os: RTL and testbench

Next-generation SPI slave for the heater controller's sensor/host link. Unlike the previous slave, it runs entirely on the system clock and oversamples SCLK, SC0 and MOSI. It supports all four CPOL/CPHA modes and handles back-to-back frames. A small TX FIFO decouples the controller from the MISO frame timing, and received words are delivered as a word plus a one-cycle valid strobe.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_tx_fifo.sv | 85 ++++++++
 rtl/spi_slave_os.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_slave_os.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : spi_pkg                                                    |
// | Shared types and helpers for the oversampling SPI slave (state enum, |
// | latched mode struct, counter/pointer width helper).                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package spi_pkg;

   // Frame sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      XFER = 2'd2
   } state_t;

   // Clock polarity / phase captured at frame start
   typedef struct packed {
      logic cpol;
      logic cpha;
   } mode_t;

   // Bits needed to index n items (at least one bit)
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_tx_fifo                                                |
// | Synchronous transmit FIFO with registered overflow pulse. A push     |
// | while full is dropped unless a pop frees a slot in the same cycle.   |
// | A pop while empty is ignored.                                        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int            PW     = cnt_w(DEPTH);
   localparam logic [PW:0]   C_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             do_push, do_pop;

   assign full     = (count_q == C_FULL);
   assign empty    = (count_q == '0);
   assign head     = mem_q[rd_ptr_q];
   assign overflow = overflow_q;

   // Next-state: a simultaneous pop frees the slot a full-FIFO push needs
   always_comb begin
      do_pop     = pop & ~empty;
      do_push    = push & (~full | do_pop);
      overflow_d = push & ~do_push;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   // Storage, pointers and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_slave_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_slave_os                                               |
// | Oversampling SPI slave on the system clock. SCLK/SC0/MOSI are        |
// | synchronised and edge-detected; all four CPOL/CPHA modes and         |
// | back-to-back frames are supported. TX words come from a small FIFO.  |
// | Option  : define SPI_LSB_FIRST_EN for LSB-first shifting both ways.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spi_slave_os
   import spi_pkg::*;
#(
   parameter int WIDTH       = 12,
   parameter int TX_DEPTH    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SCLK,
   input  logic             SC0,
   input  logic             MOSI,
   output logic             MISO,
   input  logic             CPOL,
   input  logic             CPHA,
   input  logic [WIDTH-1:0] DATA_MISO,
   input  logic             MISOflag,
   output logic             tx_full,
   output logic             tx_empty,
   output logic [WIDTH-1:0] DATA_MOSI,
   output logic             dflag,
   output logic             overflow,
   output logic             underrun,
   output logic             frame_err
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

   // Synchronisers and edge detection
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] sc0_sync_q,  sc0_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sc0_prev_q;
   logic                   sclk_s, sc0_s, mosi_s;
   logic                   sclk_rise, sclk_fall, sc0_fall, lead, trail;

   // Frame state
   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             started_q, started_d;
   logic             pending_q, pending_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic             miso_q, miso_d;
   logic [WIDTH-1:0] data_mosi_q, data_mosi_d;
   logic             dflag_q, dflag_d;
   logic             underrun_q, underrun_d;
   logic             frame_err_q, frame_err_d;

   // FIFO interface and shift helpers
   logic [WIDTH-1:0] fifo_head, load_word, tx_shifted, rx_shifted;
   logic             fifo_empty, fifo_pop, load_first, tx_next_bit;
   logic             sample_ev, shift_ev;

   spi_tx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (MISOflag),
      .push_data (DATA_MISO),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (tx_full),
      .empty     (fifo_empty),
      .overflow  (overflow)
   );

   assign tx_empty  = fifo_empty;
   assign MISO      = miso_q;
   assign DATA_MOSI = data_mosi_q;
   assign dflag     = dflag_q;
   assign underrun  = underrun_q;
   assign frame_err = frame_err_q;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sc0_s     = sc0_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign sc0_fall  = ~sc0_s & sc0_prev_q;
   assign lead      = mode_q.cpol ? sclk_fall : sclk_rise;
   assign trail     = mode_q.cpol ? sclk_rise : sclk_fall;
   assign load_word = fifo_empty ? '0 : fifo_head;

   // Synchroniser shift chains
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      sc0_sync_d  = {sc0_sync_q[SYNC_STAGES-2:0],  SC0};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
   end

   // Bit-order dependent shift paths
   always_comb begin
`ifdef SPI_LSB_FIRST_EN
      load_first  = load_word[0];
      tx_shifted  = {1'b0, tx_q[WIDTH-1:1]};
      tx_next_bit = tx_q[1];
      rx_shifted  = {mosi_s, rx_q[WIDTH-1:1]};
`else
      load_first  = load_word[WIDTH-1];
      tx_shifted  = {tx_q[WIDTH-2:0], 1'b0};
      tx_next_bit = tx_q[WIDTH-2];
      rx_shifted  = {rx_q[WIDTH-2:0], mosi_s};
`endif
   end

   // Frame sequencing: next state, shift/sample actions and status pulses.
   // The FIFO pop is committed on the first sample rather than in LOAD, so a
   // frame that ends (SC0 high) before any sample leaves the word queued.
   // Edges before the first leading edge of a frame are stale (the trailing
   // edge of the previous frame) and must not shift.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      started_d   = started_q;
      pending_d   = pending_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      miso_d      = miso_q;
      data_mosi_d = data_mosi_q;
      dflag_d     = 1'b0;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
      fifo_pop    = 1'b0;
      sample_ev   = mode_q.cpha ? trail : lead;
      shift_ev    = (mode_q.cpha ? lead : trail) & started_q;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            cnt_d  = '0;
            if (sc0_fall) begin
               mode_d  = '{cpol: CPOL, cpha: CPHA};
               state_d = LOAD;
            end
         end
         LOAD: begin
            tx_d       = load_word;
            miso_d     = load_first;
            pending_d  = ~fifo_empty;
            underrun_d = fifo_empty;
            cnt_d      = '0;
            started_d  = 1'b0;
            state_d    = XFER;
         end
         XFER: begin
            if (sc0_s) begin
               frame_err_d = (cnt_q != '0);
               pending_d   = 1'b0;
               miso_d      = 1'b0;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               if (lead) begin
                  started_d = 1'b1;
               end
               if (shift_ev) begin
                  tx_d   = tx_shifted;
                  miso_d = tx_next_bit;
               end
               if (sample_ev) begin
                  rx_d      = rx_shifted;
                  fifo_pop  = pending_q;
                  pending_d = 1'b0;
                  cnt_d     = cnt_q + CW'(1);
                  if (cnt_q == LAST_BIT) begin
                     data_mosi_d = rx_shifted;
                     dflag_d     = 1'b1;
                     cnt_d       = '0;
                     // SC0 is known low here, so the next frame follows
                     state_d     = LOAD;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sclk_sync_q <= '0;
         sc0_sync_q  <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         sc0_prev_q  <= 1'b1;
         state_q     <= IDLE;
         mode_q      <= '0;
         cnt_q       <= '0;
         started_q   <= 1'b0;
         pending_q   <= 1'b0;
         tx_q        <= '0;
         rx_q        <= '0;
         miso_q      <= 1'b0;
         data_mosi_q <= '0;
         dflag_q     <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         sc0_sync_q  <= sc0_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_s;
         sc0_prev_q  <= sc0_s;
         state_q     <= state_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         started_q   <= started_d;
         pending_q   <= pending_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         miso_q      <= miso_d;
         data_mosi_q <= data_mosi_d;
         dflag_q     <= dflag_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_slave_os                                            |
// | Scoreboard bench for spi_slave_os: the master pushes expected RX     |
// | words into a queue, a monitor pops them on each dflag pulse.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_spi_slave_os;

   localparam int WIDTH = 12;
   localparam int HALF  = 8;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             SCLK = 1'b0;
   logic             SC0 = 1'b1;
   logic             MOSI = 1'b0;
   logic             CPOL = 1'b0;
   logic             CPHA = 1'b0;
   logic [WIDTH-1:0] DATA_MISO = '0;
   logic             MISOflag = 1'b0;
   logic             MISO, tx_full, tx_empty, dflag, overflow, underrun, frame_err;
   logic [WIDTH-1:0] DATA_MOSI;

   int               n_cmp = 0;
   int               n_bad = 0;
   int               n_und = 0;
   int               n_ovf = 0;
   int               n_ferr = 0;
   int               snap;
   logic             dflag_prev = 1'b0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] m, m2;

   spi_slave_os #(
      .WIDTH       (WIDTH),
      .TX_DEPTH    (4),
      .SYNC_STAGES (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .SCLK      (SCLK),
      .SC0       (SC0),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .CPOL      (CPOL),
      .CPHA      (CPHA),
      .DATA_MISO (DATA_MISO),
      .MISOflag  (MISOflag),
      .tx_full   (tx_full),
      .tx_empty  (tx_empty),
      .DATA_MOSI (DATA_MOSI),
      .dflag     (dflag),
      .overflow  (overflow),
      .underrun  (underrun),
      .frame_err (frame_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare every received word against the scoreboard queue
   always @(negedge CLK) begin
      if (dflag_prev) chk("dflag_width", {31'd0, dflag}, 32'd0);
      if (dflag) begin
         if (exp_q.size() == 0) chk("unexpected_dflag", {31'd0, dflag}, 32'd0);
         else chk("rx_word", {20'd0, DATA_MOSI}, {20'd0, exp_q.pop_front()});
      end
      if (underrun)  n_und++;
      if (overflow)  n_ovf++;
      if (frame_err) n_ferr++;
      dflag_prev = dflag;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      @(negedge CLK);
      MISOflag  = 1'b1;
      DATA_MISO = w;
      @(negedge CLK);
      MISOflag  = 1'b0;
   endtask

   task automatic start_cs(input logic pol, input logic pha);
      CPOL = pol;
      CPHA = pha;
      SCLK = pol;
      wait_cyc(4);
      SC0 = 1'b0;
      wait_cyc(10);
   endtask

   task automatic end_cs();
      wait_cyc(4);
      SC0 = 1'b1;
      wait_cyc(12);
   endtask

   // Master clocks nbits MSB first and captures MISO at each sample edge
   task automatic bits(input logic [WIDTH-1:0] w, input int nbits, output logic [WIDTH-1:0] mw);
      mw = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!CPHA) begin
            MOSI = w[WIDTH-1-i];
            wait_cyc(HALF);
            mw   = {mw[WIDTH-2:0], MISO};
            SCLK = ~SCLK;
            wait_cyc(HALF);
            SCLK = ~SCLK;
         end else begin
            SCLK = ~SCLK;
            MOSI = w[WIDTH-1-i];
            wait_cyc(HALF);
            mw   = {mw[WIDTH-2:0], MISO};
            SCLK = ~SCLK;
            wait_cyc(HALF);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      wait_cyc(3);
      chk("rst_miso",      {31'd0, MISO}, 32'd0);
      chk("rst_data_mosi", {20'd0, DATA_MOSI}, 32'd0);
      chk("rst_dflag",     {31'd0, dflag}, 32'd0);
      chk("rst_overflow",  {31'd0, overflow}, 32'd0);
      chk("rst_underrun",  {31'd0, underrun}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_tx_empty",  {31'd0, tx_empty}, 32'd1);
      chk("rst_tx_full",   {31'd0, tx_full}, 32'd0);
      RST = 1'b0;
      wait_cyc(3);

      // Mode 0 single frame
      push(12'h4CC);
      start_cs(1'b0, 1'b0);
      exp_q.push_back(12'hA5C);
      bits(12'hA5C, WIDTH, m);
      end_cs();
      chk("t1_miso", {20'd0, m}, 32'h4CC);
      chk("t1_tx_empty", {31'd0, tx_empty}, 32'd1);

      // Mode 3 back-to-back frames
      push(12'hD6B);
      push(12'h123);
      start_cs(1'b1, 1'b1);
      exp_q.push_back(12'h0F1);
      bits(12'h0F1, WIDTH, m);
      exp_q.push_back(12'hFFE);
      bits(12'hFFE, WIDTH, m2);
      end_cs();
      chk("t2_miso_a", {20'd0, m}, 32'hD6B);
      chk("t2_miso_b", {20'd0, m2}, 32'h123);

      // Mode 1 with empty FIFO
      snap = n_und;
      start_cs(1'b0, 1'b1);
      chk("t3_underrun", n_und - snap, 32'd1);
      exp_q.push_back(12'h555);
      bits(12'h555, WIDTH, m);
      end_cs();
      chk("t3_miso_zero", {20'd0, m}, 32'd0);

      // Mode 2 abort after 5 bits, then a full frame
      snap = n_ferr;
      start_cs(1'b1, 1'b0);
      bits(12'h3C0, 5, m);
      end_cs();
      chk("t4_frame_err", n_ferr - snap, 32'd1);
      chk("t4_data_kept", {20'd0, DATA_MOSI}, 32'h555);
      start_cs(1'b1, 1'b0);
      exp_q.push_back(12'h9B4);
      bits(12'h9B4, WIDTH, m);
      end_cs();
      chk("t4_no_more_err", n_ferr - snap, 32'd1);

      // FIFO fill and overflow, then drain in order
      snap = n_ovf;
      push(12'h111);
      push(12'h222);
      push(12'h333);
      chk("t5_not_full", {31'd0, tx_full}, 32'd0);
      push(12'h444);
      chk("t5_full", {31'd0, tx_full}, 32'd1);
      push(12'h555);
      wait_cyc(3);
      chk("t5_overflow", n_ovf - snap, 32'd1);
      chk("t5_still_full", {31'd0, tx_full}, 32'd1);
      start_cs(1'b0, 1'b0); exp_q.push_back(12'h800); bits(12'h800, WIDTH, m); end_cs();
      chk("t5_word0", {20'd0, m}, 32'h111);
      start_cs(1'b0, 1'b0); exp_q.push_back(12'h001); bits(12'h001, WIDTH, m); end_cs();
      chk("t5_word1", {20'd0, m}, 32'h222);
      start_cs(1'b0, 1'b0); exp_q.push_back(12'hFFF); bits(12'hFFF, WIDTH, m); end_cs();
      chk("t5_word2", {20'd0, m}, 32'h333);
      start_cs(1'b0, 1'b0); exp_q.push_back(12'h6A9); bits(12'h6A9, WIDTH, m); end_cs();
      chk("t5_word3", {20'd0, m}, 32'h444);
      chk("t5_drained", {31'd0, tx_empty}, 32'd1);

      // Reset mid-frame after 7 bits
      push(12'hABC);
      push(12'hDEF);
      start_cs(1'b0, 1'b0);
      bits(12'h7E1, 7, m);
      @(negedge CLK);
      RST  = 1'b1;
      SC0  = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      #1;
      chk("t6_miso",      {31'd0, MISO}, 32'd0);
      chk("t6_data_mosi", {20'd0, DATA_MOSI}, 32'd0);
      chk("t6_dflag",     {31'd0, dflag}, 32'd0);
      chk("t6_tx_empty",  {31'd0, tx_empty}, 32'd1);
      chk("t6_tx_full",   {31'd0, tx_full}, 32'd0);
      wait_cyc(3);
      RST = 1'b0;
      wait_cyc(3);
      push(12'h5A5);
      start_cs(1'b0, 1'b0);
      exp_q.push_back(12'h3A7);
      bits(12'h3A7, WIDTH, m);
      end_cs();
      chk("t6_miso_word", {20'd0, m}, 32'h5A5);

      wait_cyc(10);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
